// File: rtl/laser_link_pkg.sv
// laser_link_pkg: shared types and defaults for the laser receive path.
// Holds the deframer state enum, default frame constants and checksum width.
package laser_link_pkg;

  localparam int         DEF_MAX_PAYLOAD    = 16;
  localparam logic [7:0] DEF_SYNC_BYTE      = 8'h7E;
  localparam int         DEF_TIMEOUT_CYCLES = 4096;
  localparam int         CHK_W              = 8;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK,
    DRAIN
  } rx_state_e;

  function automatic logic [CHK_W-1:0] chk_step(
    input logic [CHK_W-1:0] c,
    input logic [7:0]       b
  );
    return c ^ b;
  endfunction

endpackage

// File: rtl/laser_rx_deframer_if.sv
// laser_rx_deframer_if: receiver byte stream plus FTDI write-queue port.
// slave: deframer view (takes rx bytes, drives wrreq/data_wr); master: peer view.
interface laser_rx_deframer_if;

  logic       data_valid;
  logic [7:0] data_in;
  logic       wrq_full;
  logic       wrreq;
  logic [7:0] data_wr;

  modport slave (
    input  data_valid,
    input  data_in,
    input  wrq_full,
    output wrreq,
    output data_wr
  );

  modport master (
    output data_valid,
    output data_in,
    output wrq_full,
    input  wrreq,
    input  data_wr
  );

endinterface

// File: rtl/payload_buffer.sv
// payload_buffer: DEPTH x 8 register array, sync write, async read.
// Ports: clock, we/waddr/wdata write port, raddr/rdata read port.
module payload_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/laser_rx_deframer.sv
// laser_rx_deframer: hunts SYNC/LEN/payload/CHK frames, drains good payloads.
// Ports: clock, reset (async low), en, bus (rx stream + FTDI write queue),
// pkt_good/pkt_bad/overrun pulses, busy, and *_count stats outputs.
// Stats counters exist only when LASER_DEFRAME_STATS_EN is defined,
// otherwise the count outputs are tied to zero.
module laser_rx_deframer
  import laser_link_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = DEF_MAX_PAYLOAD,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  laser_rx_deframer_if.slave  bus,
  output logic                pkt_good,
  output logic                pkt_bad,
  output logic                overrun,
  output logic                busy,
  output logic [15:0]         good_count,
  output logic [15:0]         bad_count,
  output logic [15:0]         overrun_count
);

  localparam int IW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ?
                      $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [TW-1:0] IDLE_ONE = TW'(1);
  localparam logic [TW-1:0] IDLE_MAX =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    LEN_MAX  = 8'(MAX_PAYLOAD);

  rx_state_e         state_q, state_d;
  logic [IW-1:0]     len_q, len_d;
  logic [CHK_W-1:0]  chk_q, chk_d;
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              good_q, good_d;
  logic              bad_q, bad_d;
  logic              ovr_q, ovr_d;

  logic              dv;
  logic [7:0]        din;
  logic              timed;
  logic              tmo;
  logic              buf_we;
  logic              wr_fire;
  logic [7:0]        buf_rdata;

  assign dv    = bus.data_valid;
  assign din   = bus.data_in;
  assign timed = (state_q == LEN) ||
                 (state_q == PAYLOAD) ||
                 (state_q == CHECK);
  // A byte in the same cycle as the timeout wins.
  assign tmo   = timed && !dv && (idle_q == IDLE_MAX);

  payload_buffer #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (wr_idx_q[AW-1:0]),
    .wdata (din),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    chk_d    = chk_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    good_d   = 1'b0;
    bad_d    = 1'b0;
    ovr_d    = 1'b0;
    buf_we   = 1'b0;
    wr_fire  = 1'b0;

    if (!en) begin
      state_d  = HUNT;
      wr_idx_d = '0;
      rd_idx_d = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (dv && din == SYNC_BYTE) begin
            state_d = LEN;
          end
        end
        LEN: begin
          if (dv) begin
            if (din == 8'h00 || din > LEN_MAX) begin
              bad_d   = 1'b1;
              state_d = HUNT;
            end else begin
              len_d    = din[IW-1:0];
              chk_d    = din;
              wr_idx_d = '0;
              state_d  = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (dv) begin
            buf_we   = 1'b1;
            chk_d    = chk_step(chk_q, din);
            wr_idx_d = wr_idx_q + IDX_ONE;
            if (wr_idx_q + IDX_ONE == len_q) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (dv) begin
            if (din == chk_q) begin
              state_d  = DRAIN;
              rd_idx_d = '0;
              good_d   = 1'b1;
            end else begin
              bad_d   = 1'b1;
              state_d = HUNT;
            end
          end
        end
        DRAIN: begin
          // Bytes arriving now have nowhere to go.
          ovr_d = dv;
          if (!bus.wrq_full) begin
            wr_fire = 1'b1;
            if (rd_idx_q + IDX_ONE == len_q) begin
              state_d  = HUNT;
              rd_idx_d = '0;
            end else begin
              rd_idx_d = rd_idx_q + IDX_ONE;
            end
          end
        end
        default: state_d = HUNT;
      endcase

      if (tmo) begin
        bad_d   = 1'b1;
        state_d = HUNT;
      end
    end

    if (dv || state_d != state_q || !timed) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + IDLE_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      len_q    <= '0;
      chk_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      idle_q   <= '0;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      chk_q    <= chk_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      idle_q   <= idle_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.wrreq   = wr_fire;
  assign bus.data_wr = (state_q == DRAIN) ?
                       buf_rdata : 8'h00;
  assign pkt_good    = good_q;
  assign pkt_bad     = bad_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != HUNT);

`ifdef LASER_DEFRAME_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    ovr_cnt_d  = ovr_cnt_q;
    if (good_q && good_cnt_q != 16'hFFFF) begin
      good_cnt_d = good_cnt_q + 16'd1;
    end
    if (bad_q && bad_cnt_q != 16'hFFFF) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end
    if (ovr_q && ovr_cnt_q != 16'hFFFF) begin
      ovr_cnt_d = ovr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign good_count    = good_cnt_q;
  assign bad_count     = bad_cnt_q;
  assign overrun_count = ovr_cnt_q;
`else
  assign good_count    = 16'h0000;
  assign bad_count     = 16'h0000;
  assign overrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_laser_rx_deframer.sv
// tb_laser_rx_deframer: directed frames with a queued scoreboard.
// Stimulus pushes expected pulses/writes; a negedge monitor pops and compares.
module tb_laser_rx_deframer;

  localparam int TMO    = 4096;
  localparam int EV_GOOD = 1;
  localparam int EV_BAD  = 2;
  localparam int EV_OVR  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b1;
  logic        pkt_good, pkt_bad, overrun, busy;
  logic [15:0] good_count, bad_count, overrun_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] wr_q [$];
  int         ev_q [$];

  laser_rx_deframer_if bus ();

  laser_rx_deframer dut (
    .clock         (clock),
    .reset         (reset),
    .en            (en),
    .bus           (bus),
    .pkt_good      (pkt_good),
    .pkt_bad       (pkt_bad),
    .overrun       (overrun),
    .busy          (busy),
    .good_count    (good_count),
    .bad_count     (bad_count),
    .overrun_count (overrun_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic pop_ev(input int kind, input string name);
    if (ev_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected pulse expected none",
               name);
    end else begin
      check(name, kind, ev_q.pop_front());
    end
  endtask

  always @(negedge clock) begin
    if (pkt_good) pop_ev(EV_GOOD, "pkt_good");
    if (pkt_bad)  pop_ev(EV_BAD, "pkt_bad");
    if (overrun)  pop_ev(EV_OVR, "overrun");
    if (bus.wrreq) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_wr: got write %0h expected none",
                 bus.data_wr);
      end else begin
        check("data_wr", bus.data_wr, wr_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    @(posedge clock);
    #1;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic send_good3();
    send(8'h7E); send(8'h03); send(8'h41);
    send(8'h42); send(8'h43); send(8'h43);
  endtask

  task automatic send_frame2();
    send(8'h7E); send(8'h02); send(8'h11);
    send(8'h22); send(8'h31);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    bus.wrq_full   = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_wrreq", bus.wrreq, 0);
    check("rst_data_wr", bus.data_wr, 0);
    check("rst_good", pkt_good, 0);
    check("rst_bad", pkt_bad, 0);
    check("rst_ovr", overrun, 0);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    // good frame
    ev_q.push_back(EV_GOOD);
    wr_q.push_back(8'h41);
    wr_q.push_back(8'h42);
    wr_q.push_back(8'h43);
    send_good3();
    idle(3);
    check("busy_after_good", busy, 0);

    // bad checksum, then a one-byte good frame
    ev_q.push_back(EV_BAD);
    send(8'h7E); send(8'h03); send(8'h41);
    send(8'h42); send(8'h43); send(8'h44);
    idle(2);
    check("busy_after_badchk", busy, 0);
    ev_q.push_back(EV_GOOD);
    wr_q.push_back(8'h55);
    send(8'h7E); send(8'h01); send(8'h55); send(8'h54);
    idle(3);

    // illegal LEN values
    ev_q.push_back(EV_BAD);
    send(8'h7E); send(8'h00);
    idle(2);
    check("busy_len0", busy, 0);
    ev_q.push_back(EV_BAD);
    send(8'h7E); send(8'h11);
    idle(2);
    check("busy_len17", busy, 0);

    // backpressure with an overrun byte while stalled
    bus.wrq_full = 1'b1;
    ev_q.push_back(EV_GOOD);
    wr_q.push_back(8'h41);
    wr_q.push_back(8'h42);
    wr_q.push_back(8'h43);
    ev_q.push_back(EV_OVR);
    send_good3();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_wrreq", bus.wrreq, 0);
      check("stall_data_wr", bus.data_wr, 8'h41);
    end
    send(8'h99);
    bus.wrq_full = 1'b0;
    wait_idle("busy_after_drain");

    // timeout inside PAYLOAD, exact boundary
    ev_q.push_back(EV_BAD);
    send(8'h7E); send(8'h02); send(8'h41);
    idle(TMO - 1);
    check("busy_before_tmo", busy, 1);
    idle(1);
    check("busy_at_tmo", busy, 0);
    send(8'h42);
    idle(5);
    check("busy_late_byte", busy, 0);

    // async reset mid-drain after first write
    ev_q.push_back(EV_GOOD);
    wr_q.push_back(8'h11);
    send_frame2();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_wrreq", bus.wrreq, 0);
    check("rstmid_data_wr", bus.data_wr, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle(5);
    check("rstmid_after", busy, 0);

    // en low for one cycle mid-drain after first write
    ev_q.push_back(EV_GOOD);
    wr_q.push_back(8'h11);
    send_frame2();
    @(posedge clock);
    #1;
    en = 1'b0;
    #1;
    check("enlow_wrreq", bus.wrreq, 0);
    @(posedge clock);
    #1;
    en = 1'b1;
    check("enlow_busy", busy, 0);
    check("enlow_data_wr", bus.data_wr, 0);
    idle(5);

    check("wr_q_empty", wr_q.size(), 0);
    check("ev_q_empty", ev_q.size(), 0);
    check("good_count", good_count, 0);
    check("bad_count", bad_count, 0);
    check("overrun_count", overrun_count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
